glb_pe_gen2: RTL and testbench

GLB_PE_GEN2 -- requirements
Module: glb_pe_gen2

---
 rtl/glb_pe_gen2_if.sv | 19 +
 rtl/glb_pe_gen2.sv | 169 ++++++++++++++++
 tb/tb_glb_pe_gen2.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/glb_pe_gen2_if.sv
`default_nettype none
// ============================================================================
// glb_pe_gen2_if : multicast operand bus (valid/ready, column tag, operands)
// Revision 1.0 - initial release
// ============================================================================
interface glb_pe_gen2_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TAGW       = 3
);
  logic                  bus_valid;
  logic                  bus_ready;
  logic [TAGW-1:0]       bus_tag;
  logic [DATA_WIDTH-1:0] bus_ifmap;
  logic [DATA_WIDTH-1:0] bus_weight;

  modport master (output bus_valid, bus_tag, bus_ifmap, bus_weight, input bus_ready);
  modport slave  (input bus_valid, bus_tag, bus_ifmap, bus_weight, output bus_ready);
endinterface
`default_nettype wire

// File: rtl/glb_pe_gen2.sv
`default_nettype none
// ============================================================================
// glb_pe_gen2 : tagged multicast PE - operand FIFO feeding a signed MAC
//               that emits one partial sum per kernel_len operand pairs.
// Optional macro: GLB_PE_GEN2_SAT_EN (saturating accumulator; wraps if undefined)
// Revision 1.0 - initial release
// ============================================================================
module glb_pe_gen2 #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_COL     = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int PSUM_WIDTH  = 32,
  localparam int TAGW       = $clog2(NUM_COL) + 1,
  localparam int CNTW       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [TAGW-1:0]       tag_in,
  input  logic                  tag_load,
  input  logic                  tag_clear,
  output logic                  tag_lock,
  glb_pe_gen2_if.slave          bus,
  input  logic                  external,
  input  logic [7:0]            kernel_len,
  input  logic                  psum_in_valid,
  output logic                  psum_in_ready,
  input  logic [PSUM_WIDTH-1:0] psum_in_data,
  output logic                  psum_out_valid,
  input  logic                  psum_out_ready,
  output logic [PSUM_WIDTH-1:0] psum_out_data,
  output logic [CNTW-1:0]       fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, SEED = 2'd1, MAC = 2'd2, OUT = 2'd3} state_t;

  state_t                  state;
  logic [TAGW-1:0]         tag_q;
  logic [PW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CNTW-1:0]         count;
  logic [7:0]              klen;
  logic [7:0]              cnt;
  logic [PSUM_WIDTH-1:0]   acc;
  logic [PSUM_WIDTH-1:0]   acc_next;
  logic                    ready;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    tag_hit;
  logic                    push;
  logic                    pop;
  logic signed [DATA_WIDTH-1:0] op_a;
  logic signed [DATA_WIDTH-1:0] op_b;
  logic signed [PW-1:0]         prod;
  logic [PSUM_WIDTH-1:0]        prod_ext;

  assign fifo_full     = (count == CNTW'(FIFO_DEPTH));
  assign fifo_empty    = (count == '0);
  assign ready         = tag_lock & ~fifo_full;
  assign bus.bus_ready = ready;
  assign tag_hit       = (bus.bus_tag == tag_q) || (&bus.bus_tag);
  assign push          = bus.bus_valid & ready & tag_hit;
  assign pop           = (state == MAC) & ~fifo_empty;
  assign fifo_count    = count;
  assign psum_out_data = acc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_lock <= 1'b0;
      tag_q    <= '0;
    end else if (tag_clear) begin
      tag_lock <= 1'b0;
    end else if (tag_load && !tag_lock) begin
      tag_q    <= tag_in;
      tag_lock <= 1'b1;
    end
  end

  // Storage is not reset: clearing the pointers and count discards it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.bus_ifmap, bus.bus_weight};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign {op_a, op_b} = mem[rd_ptr];
  assign prod         = op_a * op_b;
  assign prod_ext     = {{(PSUM_WIDTH-PW){prod[PW-1]}}, prod};

`ifdef GLB_PE_GEN2_SAT_EN
  localparam logic [PSUM_WIDTH-1:0] PSUM_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic [PSUM_WIDTH-1:0] PSUM_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
  logic [PSUM_WIDTH:0] sum;
  // One guard bit: top two bits disagree exactly when the signed add overflowed.
  assign sum      = {acc[PSUM_WIDTH-1], acc} + {prod_ext[PSUM_WIDTH-1], prod_ext};
  assign acc_next = (sum[PSUM_WIDTH] == sum[PSUM_WIDTH-1]) ? sum[PSUM_WIDTH-1:0]
                  : (sum[PSUM_WIDTH] ? PSUM_MIN : PSUM_MAX);
`else
  assign acc_next = acc + prod_ext;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      acc            <= '0;
      cnt            <= '0;
      klen           <= 8'd1;
      psum_in_ready  <= 1'b0;
      psum_out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            klen <= (kernel_len == 8'd0) ? 8'd1 : kernel_len;
            cnt  <= '0;
            if (external) begin
              psum_in_ready <= 1'b1;
              state         <= SEED;
            end else begin
              acc   <= '0;
              state <= MAC;
            end
          end
        end
        SEED: begin
          if (psum_in_valid) begin
            acc           <= psum_in_data;
            cnt           <= '0;
            psum_in_ready <= 1'b0;
            state         <= MAC;
          end
        end
        MAC: begin
          if (pop) begin
            acc <= acc_next;
            cnt <= cnt + 8'd1;
            if (cnt == klen - 8'd1) begin
              psum_out_valid <= 1'b1;
              state          <= OUT;
            end
          end
        end
        OUT: begin
          if (psum_out_ready) begin
            psum_out_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_glb_pe_gen2.sv
`default_nettype none
// Bench for glb_pe_gen2: directed corner jobs plus randomized jobs, each scored
// against a transaction-level MAC model (seed + sum of products, wrap or saturate).
module tb_glb_pe_gen2;
  localparam int DW = 16, NC = 4, FD = 8, PW = 32, TAGW = 3, CNTW = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic [TAGW-1:0] tag_in;
  logic            tag_load, tag_clear, tag_lock, external;
  logic [7:0]      kernel_len;
  logic            psum_in_valid, psum_in_ready;
  logic [PW-1:0]   psum_in_data;
  logic            psum_out_valid, psum_out_ready;
  logic [PW-1:0]   psum_out_data;
  logic [CNTW-1:0] fifo_count;

  glb_pe_gen2_if #(.DATA_WIDTH(DW), .TAGW(TAGW)) bus_if ();

  glb_pe_gen2 #(.DATA_WIDTH(DW), .NUM_COL(NC), .FIFO_DEPTH(FD), .PSUM_WIDTH(PW)) dut (
    .clk(clk), .rstn(rstn), .tag_in(tag_in), .tag_load(tag_load), .tag_clear(tag_clear),
    .tag_lock(tag_lock), .bus(bus_if), .external(external), .kernel_len(kernel_len),
    .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready), .psum_in_data(psum_in_data),
    .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready),
    .psum_out_data(psum_out_data), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int              n_total = 0;
  int              n_bad = 0;
  logic [TAGW-1:0] my_tag;
  shortint         pa[$];
  shortint         pb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: seed plus pairs [lo, lo+n) accumulated in wide arithmetic.
  function automatic logic [31:0] model(input logic [31:0] seed, input int lo, input int n);
    longint s = longint'(signed'(seed));
    for (int i = lo; i < lo + n; i++) begin
      s = s + longint'(pa[i]) * longint'(pb[i]);
`ifdef GLB_PE_GEN2_SAT_EN
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      else if (s < -64'sd2147483648) s = -64'sd2147483648;
`else
      s = longint'(int'(s));
`endif
    end
    return s[31:0];
  endfunction

  function automatic shortint rnd_op();
    case ($urandom_range(0, 7))
      0:       return -32768;
      1:       return 32767;
      default: return shortint'($urandom);
    endcase
  endfunction

  function automatic logic [TAGW-1:0] junk_tag();
    logic [TAGW-1:0] t;
    do t = TAGW'($urandom_range(0, 6)); while (t == my_tag);
    return t;
  endfunction

  task automatic add_pair(input shortint a, input shortint b);
    pa.push_back(a);
    pb.push_back(b);
  endtask

  task automatic send_beat(input logic [TAGW-1:0] t, input shortint a, input shortint b);
    int n = 0;
    bus_if.bus_valid = 1'b1; bus_if.bus_tag = t;
    bus_if.bus_ifmap = a;    bus_if.bus_weight = b;
    while (!bus_if.bus_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus_if.bus_ready) check("bus_ready_timeout", bus_if.bus_ready, 1);
    @(negedge clk);
    bus_if.bus_valid = 1'b0;
  endtask

  task automatic give_seed(input logic [31:0] v);
    int n = 0;
    psum_in_valid = 1'b1; psum_in_data = v;
    while (!psum_in_ready && n < 200) begin @(negedge clk); n++; end
    if (!psum_in_ready) check("seed_timeout", psum_in_ready, 1);
    @(negedge clk);
    psum_in_valid = 1'b0;
  endtask

  task automatic take_out(input string name, input logic [31:0] exp, input int hold, input int exp_cnt);
    int n = 0;
    while (!psum_out_valid && n < 300) begin @(negedge clk); n++; end
    check({name, "_valid"}, psum_out_valid, 1);
    check({name, "_data"}, psum_out_data, exp);
    check({name, "_in_ready_low"}, psum_in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, psum_out_valid, 1);
      check({name, "_hold_data"}, psum_out_data, exp);
      if (exp_cnt >= 0) check({name, "_hold_cnt"}, fifo_count, exp_cnt);
    end
    psum_out_ready = 1'b1;
    @(negedge clk);
    psum_out_ready = 1'b0;
    check({name, "_release"}, psum_out_valid, 0);
  endtask

  // One complete output built from the pairs in pa/pb.
  task automatic run_job(input string name, input bit ext, input logic [7:0] klen,
                         input logic [31:0] seed, input bit junk, input int hold);
    logic [31:0] exp;
    check({name, "_idle_in_ready"}, psum_in_ready, 0);
    external = ext; kernel_len = klen;
    exp = model(ext ? seed : 32'd0, 0, pa.size());
    fork
      begin
        foreach (pa[i]) begin
          if (junk && $urandom_range(0, 2) == 0)
            send_beat(junk_tag(), shortint'($urandom), shortint'($urandom));
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send_beat(($urandom_range(0, 1) == 1) ? 3'd7 : my_tag, pa[i], pb[i]);
        end
      end
      begin
        if (ext) begin
          repeat ($urandom_range(0, 4)) @(negedge clk);
          give_seed(seed);
        end
      end
    join
    take_out(name, exp, hold, -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    int ke;
    logic [31:0] s;
    rstn = 1'b0; tag_in = '0; tag_load = 1'b0; tag_clear = 1'b0;
    external = 1'b0; kernel_len = 8'd1; psum_in_valid = 1'b0; psum_in_data = '0;
    psum_out_ready = 1'b0; my_tag = '0;
    bus_if.bus_valid = 1'b0; bus_if.bus_tag = '0; bus_if.bus_ifmap = '0; bus_if.bus_weight = '0;
    repeat (3) @(negedge clk);
    check("rst_bus_ready", bus_if.bus_ready, 0);
    check("rst_tag_lock", tag_lock, 0);
    check("rst_in_ready", psum_in_ready, 0);
    check("rst_out_valid", psum_out_valid, 0);
    check("rst_out_data", psum_out_data, 0);
    check("rst_fifo_count", fifo_count, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("unlocked_ready", bus_if.bus_ready, 0);

    // Clear wins over a simultaneous load.
    tag_in = 3'd2; tag_load = 1'b1; tag_clear = 1'b1;
    @(negedge clk);
    tag_load = 1'b0; tag_clear = 1'b0;
    check("clear_prio_lock", tag_lock, 0);
    tag_load = 1'b1;
    @(negedge clk);
    tag_load = 1'b0; my_tag = 3'd2;
    check("lock_set", tag_lock, 1);
    check("lock_ready", bus_if.bus_ready, 1);
    tag_in = 3'd5; tag_load = 1'b1;
    @(negedge clk);
    tag_load = 1'b0;

    // Tag filtering; the FSM parks in SEED so nothing is popped.
    external = 1'b1; kernel_len = 8'd2;
    send_beat(3'd2, 7, -3);
    send_beat(3'd1, 100, 100);
    send_beat(3'd7, -6, 4);
    send_beat(3'd5, 9, 9);
    @(negedge clk);
    check("tag_match_count", fifo_count, 2);
    check("seed_state_ready", psum_in_ready, 1);
    pa.delete(); pb.delete();
    add_pair(7, -3); add_pair(-6, 4);
    give_seed(32'd50);
    take_out("tag_job", model(32'd50, 0, 2), 0, -1);

    pa.delete(); pb.delete();
    add_pair(2, 3); add_pair(-4, 5); add_pair(1, 1);
    run_job("zero_seed", 1'b0, 8'd3, 32'd0, 1'b0, 0);
    check("zero_seed_value", psum_out_data, 32'hFFFF_FFF3);

    pa.delete(); pb.delete();
    add_pair(10, 10);
    run_job("ext_seed", 1'b1, 8'd1, 32'd100, 1'b0, 2);
    check("ext_seed_value", psum_out_data, 32'd200);

    pa.delete(); pb.delete();
    add_pair(16, 16);
    run_job("sat", 1'b1, 8'd1, 32'h7FFF_FFF0, 1'b0, 0);

    // Back-pressure: full FIFO, then a stalled output with pairs still queued.
    external = 1'b1; kernel_len = 8'd4;
    pa.delete(); pb.delete();
    for (int i = 0; i < FD; i++) begin
      add_pair(rnd_op(), rnd_op());
      send_beat(my_tag, pa[i], pb[i]);
    end
    check("bp_count_full", fifo_count, FD);
    check("bp_ready_low", bus_if.bus_ready, 0);
    bus_if.bus_valid = 1'b1; bus_if.bus_tag = my_tag;
    repeat (2) @(negedge clk);
    check("bp_count_hold", fifo_count, FD);
    bus_if.bus_valid = 1'b0;
    s = $urandom;
    give_seed(s);
    external = 1'b0;
    take_out("bp_out1", model(s, 0, 4), 5, 4);
    take_out("bp_out2", model(32'd0, 4, 4), 0, -1);

    for (int j = 0; j < 12; j++) begin
      pa.delete(); pb.delete();
      k = $urandom_range(0, 6);
      ke = (k == 0) ? 1 : k;
      for (int i = 0; i < ke; i++) add_pair(rnd_op(), rnd_op());
      run_job($sformatf("rnd%0d", j), 1'($urandom_range(0, 1)), 8'(k), $urandom, 1'b1,
              $urandom_range(0, 3));
    end

    // Asynchronous reset after 2 of 4 MACs.
    external = 1'b0; kernel_len = 8'd4;
    pa.delete(); pb.delete();
    send_beat(my_tag, 5, 6);
    send_beat(my_tag, -2, 9);
    n = 0;
    while (fifo_count != 0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid_rst_lock", tag_lock, 0);
    check("mid_rst_bus_ready", bus_if.bus_ready, 0);
    check("mid_rst_in_ready", psum_in_ready, 0);
    check("mid_rst_out_valid", psum_out_valid, 0);
    check("mid_rst_out_data", psum_out_data, 0);
    check("mid_rst_count", fifo_count, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_lock", tag_lock, 0);
    tag_in = 3'd3; tag_load = 1'b1;
    @(negedge clk);
    tag_load = 1'b0; my_tag = 3'd3;
    add_pair(3, -7);
    run_job("post_rst", 1'b0, 8'd1, 32'd0, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
